payoff_accumulator: RTL

Monte Carlo payoff accumulation stage. Consumes one terminal asset price per simulated path and computes the European call or put payoff against a latched strike. Accumulates the payoff sum and path count, then presents them in Q8.24 on `sum`/`count` with a one-cycle `out_valid` pulse. `out_valid` drives the `en` input of the downstream discount engine, which forms `exp(-rT)·sum/count`.

---
 rtl/payoff_accumulator.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/payoff_accumulator.sv
// Monte Carlo payoff accumulation stage: European call/put payoff per path,
// summed in a wide accumulator and presented as saturated Q8.24 sum and count.
module payoff_accumulator #(
  parameter int FRAC  = 24,
  parameter int ACC_W = 40
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [6:0]  num_paths,
  input  logic [31:0] strike,
  input  logic        is_put,
  input  logic        s_valid,
  input  logic [31:0] s_in,
  output logic [31:0] sum,
  output logic [31:0] count,
  output logic        out_valid,
  output logic        done,
  output logic        busy,
  output logic        overflow
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [31:0]        strike_q, strike_d;
  logic               is_put_q, is_put_d;
  logic [6:0]         num_paths_q, num_paths_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [6:0]         cnt_q, cnt_d;
  logic [31:0]        sum_q, sum_d;
  logic [31:0]        count_q, count_d;
  logic               overflow_q, overflow_d;
  logic               out_valid_q, out_valid_d;
  logic               done_q, done_d;
  logic               busy_q, busy_d;

  logic               start_ok;
  logic signed [32:0] price_ext;
  logic signed [32:0] strike_ext;
  logic signed [32:0] diff;
  logic [32:0]        payoff;
  logic [ACC_W-1:0]   acc_sum;
  logic [6:0]         cnt_inc;
  logic [31:0]        cnt_ext;
  logic               acc_big;

  // Payoff datapath is evaluated every cycle; it is only committed on an accepted sample.
  always_comb begin
    start_ok   = start && (num_paths != 7'd0);
    price_ext  = {s_in[31], s_in};
    strike_ext = {strike_q[31], strike_q};
    diff       = is_put_q ? (strike_ext - price_ext) : (price_ext - strike_ext);
    payoff     = diff[32] ? 33'd0 : diff;
    acc_sum    = acc_q + {{(ACC_W-33){1'b0}}, payoff};
    cnt_inc    = cnt_q + 7'd1;
    cnt_ext    = {25'd0, cnt_inc};
    acc_big    = |acc_sum[ACC_W-1:31];
  end

  always_comb begin
    state_d     = state_q;
    strike_d    = strike_q;
    is_put_d    = is_put_q;
    num_paths_d = num_paths_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    sum_d       = sum_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    out_valid_d = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        if (start_ok) begin
          state_d     = ACCUM;
          strike_d    = strike;
          is_put_d    = is_put;
          num_paths_d = num_paths;
          acc_d       = '0;
          cnt_d       = '0;
          sum_d       = '0;
          count_d     = '0;
          overflow_d  = 1'b0;
        end
      end
      ACCUM: begin
        if (s_valid) begin
          acc_d      = acc_sum;
          cnt_d      = cnt_inc;
          sum_d      = acc_big ? 32'h7FFF_FFFF : acc_sum[31:0];
          overflow_d = overflow_q | acc_big;
          count_d    = cnt_ext << FRAC;
          if (cnt_inc == num_paths_q) begin
            state_d     = DONE;
            out_valid_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == ACCUM);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      strike_q    <= '0;
      is_put_q    <= 1'b0;
      num_paths_q <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      sum_q       <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      strike_q    <= strike_d;
      is_put_q    <= is_put_d;
      num_paths_q <= num_paths_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      sum_q       <= sum_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      out_valid_q <= out_valid_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
    end
  end

  assign sum       = sum_q;
  assign count     = count_q;
  assign overflow  = overflow_q;
  assign out_valid = out_valid_q;
  assign done      = done_q;
  assign busy      = busy_q;

endmodule
